pipe_stall_ctrl: RTL and testbench

// - Parametrised pipeline enable/flush controller; generalises the fetch PC-enable AND-gate to N stages.
// - Merges per-stage stall requests, per-stage flush requests and a multi-cycle (mul/div) stall counter.
// - Drives pc_en plus one load-enable and one bubble/flush per pipeline register.
// - Sits beside the hazard unit and feeds every pipeline register and the PC register.

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/mc_stall_counter.sv | 55 +++++
 rtl/pipe_stall_ctrl.sv | 80 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage index constants and multi-cycle FSM state type
package pipe_ctrl_pkg;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   typedef enum logic {MC_IDLE, MC_BUSY} mc_state_t;
endpackage

// File: rtl/mc_stall_counter.sv
// mc_stall_counter: multi-cycle hold FSM; holds for exactly mc_cycles cycles, then pulses mc_done
// Ports: clk, rst (sync, active-high), mc_start (pulse), mc_cycles (hold length),
//        mc_hold (hold this cycle), mc_busy (counter active), mc_done (registered pulse)
module mc_stall_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mc_start,
   input  logic [CNT_W-1:0] mc_cycles,
   output logic             mc_hold,
   output logic             mc_busy,
   output logic             mc_done
);
   mc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   assign mc_busy = (state_q == MC_BUSY) & ~rst;
   assign mc_hold = mc_busy | (mc_start & ~mc_busy & (|mc_cycles) & ~rst);
   assign mc_done = done_q & ~rst;
   // The start cycle is the first hold cycle, so BUSY only covers the remaining N-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (state_q == MC_IDLE) begin
         if (mc_start) begin
            done_d = mc_cycles <= CNT_W'(1);
            if (mc_cycles > CNT_W'(1)) begin
               state_d = MC_BUSY;
               cnt_d   = mc_cycles - CNT_W'(1);
            end
         end
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d = MC_IDLE;
            done_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: N-stage pipeline enable/flush controller with multi-cycle stall and optional watchdog
// Ports: clk, rst (sync, active-high), pc_write, stall_req[N], flush_req[N], mc_start, mc_cycles,
//        pc_en, stage_en[N], stage_flush[N], mc_busy, mc_done, wdog_trip
// Optional feature macro: STALL_WDOG_EN (stall watchdog; wdog_trip tied 0 when undefined)
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int MC_STAGE   = STG_EX,
`ifdef STALL_WDOG_EN
   parameter int WDOG_LIMIT = 64,
`endif
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_write,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   input  logic                  mc_start,
   input  logic [CNT_W-1:0]      mc_cycles,
   output logic                  pc_en,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] stage_flush,
   output logic                  mc_busy,
   output logic                  mc_done,
   output logic                  wdog_trip
);
   logic                  mc_hold;
   logic [NUM_STAGES-1:0] hold_l, hold, bubble, pend_q, pend_d;
   mc_stall_counter #(.CNT_W(CNT_W)) u_mc (
      .clk       (clk),
      .rst       (rst),
      .mc_start  (mc_start),
      .mc_cycles (mc_cycles),
      .mc_hold   (mc_hold),
      .mc_busy   (mc_busy),
      .mc_done   (mc_done)
   );
   // A held stage freezes everything upstream of it.
   always_comb begin
      hold_l = '0;
      hold   = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         hold_l[k] = stall_req[k] | (mc_hold & (k <= MC_STAGE));
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
         hold[k] = |(hold_l >> k);
      end
   end
   // Bubble into the first running stage just downstream of a held one.
   assign bubble = ~hold & {hold[NUM_STAGES-2:0], 1'b0};
   // A flush aimed at a held stage is remembered until that stage loads.
   assign pend_d = hold & (pend_q | flush_req);
   assign pc_en       = ~rst & pc_write & ~hold[0];
   assign stage_en    = rst ? '0 : ~hold;
   assign stage_flush = rst ? '1 : (~hold & (flush_req | pend_q)) | bubble;
   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end
`ifdef STALL_WDOG_EN
   logic [7:0] wcnt_q, wcnt_d;
   logic       trip_q, trip_d;
   assign wcnt_d    = pc_en ? 8'd0 : (pc_write & (wcnt_q != 8'hff)) ? wcnt_q + 8'd1 : wcnt_q;
   assign trip_d    = trip_q | (32'(wcnt_d) >= WDOG_LIMIT);
   assign wdog_trip = trip_q & ~rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         trip_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         trip_q <= trip_d;
      end
   end
`else
   assign wdog_trip = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
   logic       clk = 1'b0;
   logic       rst, pc_write, mc_start;
   logic [4:0] stall_req, flush_req, mc_cycles;
   logic       pc_en, mc_busy, mc_done, wdog_trip;
   logic [4:0] stage_en, stage_flush;
   int         checks = 0;
   int         errors = 0;
   logic       exp_trip;
   always #5 clk = ~clk;
   pipe_stall_ctrl #(
`ifdef STALL_WDOG_EN
      .WDOG_LIMIT (8),
`endif
      .NUM_STAGES (5),
      .MC_STAGE   (2),
      .CNT_W      (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_write    (pc_write),
      .stall_req   (stall_req),
      .flush_req   (flush_req),
      .mc_start    (mc_start),
      .mc_cycles   (mc_cycles),
      .pc_en       (pc_en),
      .stage_en    (stage_en),
      .stage_flush (stage_flush),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done),
      .wdog_trip   (wdog_trip)
   );
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_all(input string tag, input logic p, input logic [4:0] en, input logic [4:0] fl,
                          input logic b, input logic d);
      chk({tag, ".pc_en"}, 32'(pc_en), 32'(p));
      chk({tag, ".stage_en"}, 32'(stage_en), 32'(en));
      chk({tag, ".stage_flush"}, 32'(stage_flush), 32'(fl));
      chk({tag, ".mc_busy"}, 32'(mc_busy), 32'(b));
      chk({tag, ".mc_done"}, 32'(mc_done), 32'(d));
   endtask
   initial begin
      rst = 1; pc_write = 1; mc_start = 0; stall_req = 0; flush_req = 0; mc_cycles = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_all("reset", 0, 5'b00000, 5'b11111, 0, 0);
         chk("reset.wdog", 32'(wdog_trip), 0);
         nxt();
      end
      rst = 0; #1;
      chk_all("release", 1, 5'b11111, 5'b00000, 0, 0);
      pc_write = 0; #1;
      chk("release.pc_write0", 32'(pc_en), 0);
      pc_write = 1;
      nxt();
      stall_req = 5'b00010; #1;
      chk_all("loaduse", 0, 5'b11100, 5'b00100, 0, 0);
      nxt(); stall_req = 0; #1;
      chk_all("loaduse.after", 1, 5'b11111, 5'b00000, 0, 0);
      nxt(); mc_start = 1; mc_cycles = 5'd4; #1;
      chk_all("mc4.c1", 0, 5'b11000, 5'b01000, 0, 0);
      nxt(); mc_cycles = 5'd9; #1;
      chk_all("mc4.c2", 0, 5'b11000, 5'b01000, 1, 0);
      nxt(); mc_start = 0; #1;
      chk_all("mc4.c3", 0, 5'b11000, 5'b01000, 1, 0);
      nxt();
      chk_all("mc4.c4", 0, 5'b11000, 5'b01000, 1, 0);
      nxt();
      chk_all("mc4.c5", 1, 5'b11111, 5'b00000, 0, 1);
      nxt();
      chk_all("mc4.c6", 1, 5'b11111, 5'b00000, 0, 0);
      stall_req = 5'b00100; flush_req = 5'b00001; #1;
      chk_all("hflush.c1", 0, 5'b11000, 5'b01000, 0, 0);
      nxt();
      chk_all("hflush.c2", 0, 5'b11000, 5'b01000, 0, 0);
      nxt(); stall_req = 0; flush_req = 0; #1;
      chk_all("hflush.rel", 1, 5'b11111, 5'b00001, 0, 0);
      nxt();
      chk_all("hflush.after", 1, 5'b11111, 5'b00000, 0, 0);
      flush_req = 5'b00010; #1;
      chk_all("flush.free", 1, 5'b11111, 5'b00010, 0, 0);
      flush_req = 0;
      nxt(); mc_start = 1; mc_cycles = 5'd0; #1;
      chk_all("mc0.c1", 1, 5'b11111, 5'b00000, 0, 0);
      nxt(); mc_start = 0; #1;
      chk_all("mc0.c2", 1, 5'b11111, 5'b00000, 0, 1);
      nxt();
      chk_all("mc0.c3", 1, 5'b11111, 5'b00000, 0, 0);
      mc_start = 1; mc_cycles = 5'd1; #1;
      chk_all("mc1.c1", 0, 5'b11000, 5'b01000, 0, 0);
      nxt(); mc_start = 0; #1;
      chk_all("mc1.c2", 1, 5'b11111, 5'b00000, 0, 1);
      nxt();
      chk_all("mc1.c3", 1, 5'b11111, 5'b00000, 0, 0);
      mc_start = 1; mc_cycles = 5'd6; stall_req = 5'b10000; #1;
      chk_all("mc6.or", 0, 5'b00000, 5'b00000, 0, 0);
      nxt(); mc_start = 0; stall_req = 0; #1;
      chk_all("mc6.busy", 0, 5'b11000, 5'b01000, 1, 0);
      nxt(); rst = 1; #1;
      chk_all("mc6.rst", 0, 5'b00000, 5'b11111, 0, 0);
      nxt(); rst = 0; #1;
      for (int i = 0; i < 7; i++) begin
         chk_all("mc6.abort", 1, 5'b11111, 5'b00000, 0, 0);
         nxt();
      end
`ifdef STALL_WDOG_EN
      exp_trip = 1;
`else
      exp_trip = 0;
`endif
      stall_req = 5'b10000; #1;
      for (int i = 0; i < 8; i++) begin
         chk("wdog.pre", 32'(wdog_trip), 0);
         nxt();
      end
      chk("wdog.trip", 32'(wdog_trip), 32'(exp_trip));
      stall_req = 0;
      nxt();
      chk("wdog.sticky", 32'(wdog_trip), 32'(exp_trip));
      chk("wdog.pc_en", 32'(pc_en), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
